// File: rtl/memory_bus_arbiter.sv
// Two-master memory bus arbiter: dbus (port 0) and ibus (port 1) share one bus.
// Requests pass through combinationally. The grant is held while the slave
// stalls, and a small owner FIFO steers in-order read responses back to the
// port that issued each read.
module memory_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dbus_address,
    input  logic [31:0] dbus_write_data,
    input  logic [3:0]  dbus_byte_enable,
    input  logic        dbus_read_enable,
    input  logic        dbus_write_enable,
    output logic        dbus_wait_req,
    output logic        dbus_valid,
    output logic [31:0] dbus_read_data,
    input  logic [31:0] ibus_address,
    input  logic [31:0] ibus_write_data,
    input  logic [3:0]  ibus_byte_enable,
    input  logic        ibus_read_enable,
    input  logic        ibus_write_enable,
    output logic        ibus_wait_req,
    output logic        ibus_valid,
    output logic [31:0] ibus_read_data,
    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic        bus_wait_req,
    input  logic        bus_valid,
    input  logic [31:0] bus_read_data,
    output logic        protocol_error
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

    // Port IDs: 0 = dbus, 1 = ibus
    logic                       last_q, last_d;
    logic                       locked_q, locked_d;
    logic                       lock_owner_q, lock_owner_d;
    logic                       perr_q, perr_d;
    logic [MAX_OUTSTANDING-1:0] owner_q, owner_d;
    logic [PW-1:0]              wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]              count_q, count_d;

    logic dreq, ireq, owner_req, hold, grant;
    logic g_re, g_we, g_wait, full, gated;
    logic accepted, push, pop, head;

    // State register: arbitration state, owner FIFO and sticky error flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q       <= 1'b1;
            locked_q     <= 1'b0;
            lock_owner_q <= 1'b0;
            perr_q       <= 1'b0;
            owner_q      <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
        end else begin
            last_q       <= last_d;
            locked_q     <= locked_d;
            lock_owner_q <= lock_owner_d;
            perr_q       <= perr_d;
            owner_q      <= owner_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
        end
    end

    // Next state: round-robin pointer, stall lock, FIFO push/pop, error flag
    always_comb begin
        last_d       = accepted ? grant : last_q;
        locked_d     = locked_q;
        lock_owner_d = lock_owner_q;
        if (accepted) begin
            locked_d = 1'b0;
        end else if ((bus_read_enable || bus_write_enable) && bus_wait_req) begin
            locked_d     = 1'b1;
            lock_owner_d = grant;
        end else if (locked_q && !owner_req) begin
            // Owner abandoned a stalled request; let the other port in
            locked_d = 1'b0;
        end

        owner_d = owner_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            owner_d[wptr_q] = grant;
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        perr_d = perr_q | (bus_valid && count_q == '0);
    end

    // Outputs: grant selection, bus mux, read gating, port waits and response steering
    always_comb begin
        dreq      = dbus_read_enable | dbus_write_enable;
        ireq      = ibus_read_enable | ibus_write_enable;
        owner_req = lock_owner_q ? ireq : dreq;
        hold      = locked_q && owner_req;

        if (hold)              grant = lock_owner_q;
        else if (dreq && ireq) grant = ~last_q;
        else                   grant = ireq;   // no requester falls back to dbus

        // Read wins over write when a port strobes both
        g_re = grant ? ibus_read_enable : dbus_read_enable;
        g_we = grant ? (ibus_write_enable & ~ibus_read_enable)
                     : (dbus_write_enable & ~dbus_read_enable);

        // Full uses the registered count; a same-cycle pop does not free a slot
        full  = (count_q == MAX_CNT);
        gated = g_re & full;

        bus_address      = grant ? ibus_address     : dbus_address;
        bus_write_data   = grant ? ibus_write_data  : dbus_write_data;
        bus_byte_enable  = grant ? ibus_byte_enable : dbus_byte_enable;
        bus_read_enable  = reset_n & g_re & ~full;
        bus_write_enable = reset_n & g_we;

        accepted = (bus_read_enable | bus_write_enable) & ~bus_wait_req;
        push     = bus_read_enable & ~bus_wait_req;

        g_wait = bus_wait_req | gated;
        if (!reset_n) begin
            dbus_wait_req = 1'b1;
            ibus_wait_req = 1'b1;
        end else begin
            dbus_wait_req = grant ? dreq : (dreq & g_wait);
            ibus_wait_req = grant ? g_wait : ireq;
        end

        pop            = bus_valid & (count_q != '0);
        head           = owner_q[rptr_q];
        dbus_valid     = reset_n & pop & ~head;
        ibus_valid     = reset_n & pop & head;
        dbus_read_data = bus_read_data;
        ibus_read_data = bus_read_data;
        protocol_error = perr_q;
    end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: single read, contention, stall lock,
// full owner FIFO, spurious response and asynchronous reset.
module tb_memory_bus_arbiter;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] dbus_address, dbus_write_data, ibus_address, ibus_write_data;
    logic [3:0]  dbus_byte_enable, ibus_byte_enable;
    logic        dbus_read_enable, dbus_write_enable, ibus_read_enable, ibus_write_enable;
    logic        dbus_wait_req, dbus_valid, ibus_wait_req, ibus_valid;
    logic [31:0] dbus_read_data, ibus_read_data;
    logic [31:0] bus_address, bus_write_data, bus_read_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable, bus_write_enable, bus_wait_req, bus_valid;
    logic        protocol_error;

    int tests = 0;
    int fails = 0;

    memory_bus_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clock(clock), .reset_n(reset_n),
        .dbus_address(dbus_address), .dbus_write_data(dbus_write_data),
        .dbus_byte_enable(dbus_byte_enable), .dbus_read_enable(dbus_read_enable),
        .dbus_write_enable(dbus_write_enable), .dbus_wait_req(dbus_wait_req),
        .dbus_valid(dbus_valid), .dbus_read_data(dbus_read_data),
        .ibus_address(ibus_address), .ibus_write_data(ibus_write_data),
        .ibus_byte_enable(ibus_byte_enable), .ibus_read_enable(ibus_read_enable),
        .ibus_write_enable(ibus_write_enable), .ibus_wait_req(ibus_wait_req),
        .ibus_valid(ibus_valid), .ibus_read_data(ibus_read_data),
        .bus_address(bus_address), .bus_write_data(bus_write_data),
        .bus_byte_enable(bus_byte_enable), .bus_read_enable(bus_read_enable),
        .bus_write_enable(bus_write_enable), .bus_wait_req(bus_wait_req),
        .bus_valid(bus_valid), .bus_read_data(bus_read_data),
        .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic dre, input logic dwe, input logic ire, input logic iwe,
                         input logic stall, input logic vld, input logic [31:0] rdata);
        dbus_read_enable  = dre;
        dbus_write_enable = dwe;
        ibus_read_enable  = ire;
        ibus_write_enable = iwe;
        bus_wait_req      = stall;
        bus_valid         = vld;
        bus_read_data     = rdata;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        dbus_address = 32'h100;  ibus_address = 32'h200;
        dbus_write_data = 32'h1111_1111; ibus_write_data = 32'h2222_2222;
        dbus_byte_enable = 4'hF; ibus_byte_enable = 4'h3;
        drive(1, 0, 0, 0, 0, 1, 32'h0);
        #2;
        // Reset state: strobes forced low, both waits high, no valids
        chk("rst_bus_re", bus_read_enable, 0);
        chk("rst_dwait", dbus_wait_req, 1);
        chk("rst_iwait", ibus_wait_req, 1);
        chk("rst_dvalid", dbus_valid, 0);
        chk("rst_perr", protocol_error, 0);
        tick();
        reset_n = 1'b1;

        // 1. Single dbus read at 0x100, answered two cycles later
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("t1_bus_re", bus_read_enable, 1);
        chk("t1_addr", bus_address, 32'h100);
        chk("t1_dwait", dbus_wait_req, 0);
        chk("t1_iwait", ibus_wait_req, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("t1_idle_re", bus_read_enable, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        #2;
        chk("t1_dvalid", dbus_valid, 1);
        chk("t1_ivalid", ibus_valid, 0);
        chk("t1_rdata", dbus_read_data, 32'hDEADBEEF);
        tick();

        // 2. ibus write so that dbus wins the next contention, then both read
        drive(0, 0, 0, 1, 0, 0, 32'h0);
        #2;
        chk("t2_iwrite", bus_write_enable, 1);
        chk("t2_iwaddr", bus_address, 32'h200);
        tick();
        dbus_address = 32'h1000; ibus_address = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 1, 0, 0, k > 0, 32'(k));
            #2;
            chk("t2_grant", bus_address, (k % 2 == 0) ? 32'h1000 : 32'h2000);
            chk("t2_dwait", dbus_wait_req, (k % 2 == 0) ? 0 : 1);
            chk("t2_iwait", ibus_wait_req, (k % 2 == 0) ? 1 : 0);
            chk("t2_re", bus_read_enable, 1);
            if (k > 0) begin
                chk("t2_dvalid", dbus_valid, ((k - 1) % 2 == 0) ? 1 : 0);
                chk("t2_ivalid", ibus_valid, ((k - 1) % 2 == 1) ? 1 : 0);
                chk("t2_rdata", ibus_read_data, 32'(k));
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 1, 32'h55);
        #2;
        chk("t2_last_ivalid", ibus_valid, 1);
        chk("t2_last_dvalid", dbus_valid, 0);
        tick();

        // 3. ibus stalled alone, dbus joins; lock keeps ibus for 4 cycles
        dbus_address = 32'h100; ibus_address = 32'h200;
        for (int c = 0; c < 4; c++) begin
            drive(c > 0, 0, 0, 1, c < 3, 0, 32'h0);
            dbus_write_enable = (c > 0);
            dbus_read_enable  = 1'b0;
            #2;
            chk("t3_lock_addr", bus_address, 32'h200);
            chk("t3_lock_we", bus_write_enable, 1);
            chk("t3_iwait", ibus_wait_req, (c < 3) ? 1 : 0);
            if (c > 0) chk("t3_dwait", dbus_wait_req, 1);
            tick();
        end
        drive(0, 1, 0, 1, 0, 0, 32'h0);
        #2;
        chk("t3_c5_addr", bus_address, 32'h100);
        chk("t3_c5_dwait", dbus_wait_req, 0);
        chk("t3_c5_iwait", ibus_wait_req, 1);
        tick();

        // 4. Three back-to-back dbus reads with MAX_OUTSTANDING=2
        dbus_address = 32'h300;
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("t4_r1_re", bus_read_enable, 1);
        tick();
        dbus_address = 32'h304;
        #2;
        chk("t4_r2_re", bus_read_enable, 1);
        chk("t4_r2_dwait", dbus_wait_req, 0);
        tick();
        dbus_address = 32'h308;
        #2;
        chk("t4_r3_gated_re", bus_read_enable, 0);
        chk("t4_r3_gated_dwait", dbus_wait_req, 1);
        tick();
        drive(1, 0, 0, 1, 0, 0, 32'h0);
        #2;
        chk("t4_iwrite_we", bus_write_enable, 1);
        chk("t4_iwrite_addr", bus_address, 32'h200);
        chk("t4_iwrite_iwait", ibus_wait_req, 0);
        chk("t4_iwrite_re", bus_read_enable, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1, 32'hA1);
        #2;
        chk("t4_pop_still_full", bus_read_enable, 0);
        chk("t4_pop_dwait", dbus_wait_req, 1);
        chk("t4_pop_dvalid", dbus_valid, 1);
        tick();
        #2;
        bus_valid = 1'b0;
        #1;
        chk("t4_r3_issue_re", bus_read_enable, 1);
        chk("t4_r3_issue_addr", bus_address, 32'h308);
        chk("t4_r3_issue_dwait", dbus_wait_req, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 32'hA2);
        #2;
        chk("t4_drain1", dbus_valid, 1);
        tick();
        #2;
        chk("t4_drain2", dbus_valid, 1);
        tick();

        // 5. Spurious valid, sticky error, asynchronous reset mid-read
        drive(0, 0, 0, 0, 0, 1, 32'h0);
        #2;
        chk("t5_spur_dvalid", dbus_valid, 0);
        chk("t5_spur_ivalid", ibus_valid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("t5_perr_set", protocol_error, 1);
        tick();
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("t5_perr_sticky", protocol_error, 1);
        chk("t5_pre_rst_re", bus_read_enable, 1);
        bus_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_re", bus_read_enable, 0);
        chk("t5_rst_dwait", dbus_wait_req, 1);
        chk("t5_rst_iwait", ibus_wait_req, 1);
        chk("t5_rst_dvalid", dbus_valid, 0);
        chk("t5_rst_perr", protocol_error, 0);
        tick();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 32'h0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
